// File: rtl/datamem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | datamem_pkg                                                      |
// | Shared access-width encoding and address constants for data_mem. |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package datamem_pkg;

    typedef enum logic [1:0] {
        WIDTH_WORD = 2'b00,
        WIDTH_BYTE = 2'b01,
        WIDTH_HALF = 2'b10
    } width_e;

    localparam int DATAMEM_ADDR_LSB = 2;

endpackage : datamem_pkg
`default_nettype wire

// File: rtl/datamem_lane_sel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | datamem_lane_sel                                                 |
// | Decodes width/offset into byte enables, replicated write data    |
// | and the zero-extending read-data extraction.                     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module datamem_lane_sel
    import datamem_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_rdata
);

    always_comb begin
        o_be        = 4'b1111;
        o_wdata_rep = i_wdata;
        o_rdata     = i_rword;
        // Low offset bits below the access size are dropped; 2'b11 is treated as a word.
        case (i_width)
            WIDTH_HALF: begin
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_rdata     = {16'b0, (i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0])};
            end
            WIDTH_BYTE: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata_rep = {4{i_wdata[7:0]}};
                case (i_addr_lo)
                    2'd0:    o_rdata = {24'b0, i_rword[7:0]};
                    2'd1:    o_rdata = {24'b0, i_rword[15:8]};
                    2'd2:    o_rdata = {24'b0, i_rword[23:16]};
                    default: o_rdata = {24'b0, i_rword[31:24]};
                endcase
            end
            default: begin
                o_be        = 4'b1111;
                o_wdata_rep = i_wdata;
                o_rdata     = i_rword;
            end
        endcase
    end

endmodule : datamem_lane_sel
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_mem                                                         |
// | Byte-addressable little-endian data memory, combinational read.  |
// | Optional: DATAMEM_MISALIGN_CHECK_EN adds MisalignedFlag and      |
// | suppresses misaligned writes.                                    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module data_mem
    import datamem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [1:0]  WidthSrc,
    input  logic [31:0] A,
    input  logic [31:0] WD,
`ifdef DATAMEM_MISALIGN_CHECK_EN
    output logic        MisalignedFlag,
`endif
    output logic [31:0] RD
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]        mem_q [DEPTH_WORDS];
    logic [31:0]        mem_d [DEPTH_WORDS];
    logic [c_IDX_W-1:0] w_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_rep;
    logic               w_wr_en;
    logic               w_unused_addr;

    // Upper address bits are ignored so the space wraps.
    assign w_idx         = A[c_IDX_W+DATAMEM_ADDR_LSB-1:DATAMEM_ADDR_LSB];
    assign w_unused_addr = ^A[31:c_IDX_W+DATAMEM_ADDR_LSB];

`ifdef DATAMEM_MISALIGN_CHECK_EN
    logic w_misaligned;
    always_comb begin
        w_misaligned = 1'b0;
        case (WidthSrc)
            WIDTH_BYTE: w_misaligned = 1'b0;
            WIDTH_HALF: w_misaligned = A[0];
            default:    w_misaligned = |A[1:0];
        endcase
    end
    assign MisalignedFlag = w_misaligned;
    assign w_wr_en        = WE & ~w_misaligned;
`else
    assign w_wr_en = WE;
`endif

    datamem_lane_sel u_lane_sel (
        .i_width     (WidthSrc),
        .i_addr_lo   (A[1:0]),
        .i_wdata     (WD),
        .i_rword     (mem_q[w_idx]),
        .o_be        (w_be),
        .o_wdata_rep (w_wdata_rep),
        .o_rdata     (RD)
    );

    always_comb begin
        mem_d = mem_q;
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_d[w_idx][8*b +: 8] = w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule : data_mem
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_data_mem                                                      |
// | Self-checking bench for data_mem against a byte-array model.     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_data_mem;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [1:0]  WidthSrc;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
`ifdef DATAMEM_MISALIGN_CHECK_EN
    logic        MisalignedFlag;
`endif

    int n_checks;
    int n_errors;

    logic [7:0] ref_mem [256];

    data_mem #(.DEPTH_WORDS(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .WE       (WE),
        .WidthSrc (WidthSrc),
        .A        (A),
        .WD       (WD),
`ifdef DATAMEM_MISALIGN_CHECK_EN
        .MisalignedFlag (MisalignedFlag),
`endif
        .RD       (RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_misaligned(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'b01) return 1'b0;
        if (w == 2'b10) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] ref_read(input logic [1:0] w, input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        if (w == 2'b01) return {24'b0, ref_mem[b]};
        if (w == 2'b10) begin
            b[0] = 1'b0;
            return {16'b0, ref_mem[b + 8'd1], ref_mem[b]};
        end
        b[1:0] = 2'b00;
        return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
    endfunction

    task automatic ref_write(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] b;
        int n;
        b = a[7:0];
`ifdef DATAMEM_MISALIGN_CHECK_EN
        if (ref_misaligned(w, a)) return;
`endif
        if (w == 2'b01) n = 1;
        else if (w == 2'b10) n = 2;
        else n = 4;
        b = b & ~(8'(n - 1));
        for (int k = 0; k < n; k++) ref_mem[b + 8'(k)] = d[8*k +: 8];
    endtask

    // One clock edge; inputs settle 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        WE = we; WidthSrc = w; A = a; WD = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick(); tick();
        reset = 1'b0;
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            A = 32'(i * 36);
            WidthSrc = 2'b00;
            #1;
            n_checks++;
            if (RD !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_rd A=%h got=%h exp=%h", A, RD, 32'h0);
            end
        end
    endtask

    task automatic test_word_fill();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 2'b00, 32'(4 * i), 32'(i));
            tick();
            ref_write(2'b00, 32'(4 * i), 32'(i));
            n_checks++;
            if (RD !== 32'(i)) begin
                n_errors++;
                $display("FAIL word_fill i=%0d got=%h exp=%h", i, RD, 32'(i));
            end
        end
    endtask

    task automatic test_half_fill();
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, 2'b10, 32'(2 * i), 32'(i));
            tick();
            ref_write(2'b10, 32'(2 * i), 32'(i));
        end
        WE = 1'b0;
        for (int i = 0; i < 128; i++) begin
            A = 32'(2 * i);
            #1;
            n_checks++;
            if (RD !== 32'(i)) begin
                n_errors++;
                $display("FAIL half_fill i=%0d got=%h exp=%h", i, RD, 32'(i));
            end
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        n_checks++;
        if (RD !== 32'h0001_0000) begin
            n_errors++;
            $display("FAIL half_word0 got=%h exp=%h", RD, 32'h0001_0000);
        end
    endtask

    task automatic test_byte_fill();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 2'b01, 32'(i), 32'(i));
            tick();
            ref_write(2'b01, 32'(i), 32'(i));
        end
        WE = 1'b0;
        for (int i = 0; i < 256; i++) begin
            A = 32'(i);
            #1;
            n_checks++;
            if (RD !== 32'(i)) begin
                n_errors++;
                $display("FAIL byte_fill i=%0d got=%h exp=%h", i, RD, 32'(i));
            end
        end
        drive(1'b0, 2'b00, 32'h4, 32'h0);
        #1;
        n_checks++;
        if (RD !== 32'h0706_0504) begin
            n_errors++;
            $display("FAIL byte_word4 got=%h exp=%h", RD, 32'h0706_0504);
        end
    endtask

    task automatic test_partial();
        drive(1'b1, 2'b00, 32'h8, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 2'b01, 32'h9, 32'h0000_0055);
        tick();
        ref_write(2'b00, 32'h8, 32'hDEAD_BEEF);
        ref_write(2'b01, 32'h9, 32'h55);
        drive(1'b0, 2'b00, 32'h8, 32'h0);
        #1;
        n_checks++;
        if (RD !== 32'hDEAD_55EF) begin
            n_errors++;
            $display("FAIL partial_word got=%h exp=%h", RD, 32'hDEAD_55EF);
        end
        drive(1'b0, 2'b10, 32'hA, 32'h0);
        #1;
        n_checks++;
        if (RD !== 32'h0000_DEAD) begin
            n_errors++;
            $display("FAIL partial_half got=%h exp=%h", RD, 32'h0000_DEAD);
        end
        // Misaligned word read uses the aligned-down word.
        drive(1'b0, 2'b00, 32'hB, 32'h0);
        #1;
        n_checks++;
        if (RD !== 32'hDEAD_55EF) begin
            n_errors++;
            $display("FAIL misaligned_word_rd got=%h exp=%h", RD, 32'hDEAD_55EF);
        end
    endtask

    task automatic test_reset_wins();
        reset = 1'b1;
        drive(1'b1, 2'b00, 32'h10, 32'hFFFF_FFFF);
        tick();
        reset = 1'b0;
        WE = 1'b0;
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        for (int i = 0; i < 64; i++) begin
            A = 32'(4 * i);
            #1;
            n_checks++;
            if (RD !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_wins A=%h got=%h exp=%h", A, RD, 32'h0);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_v;
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            #1;
            exp_v = ref_read(WidthSrc, A);
            n_checks++;
            if (RD !== exp_v) begin
                n_errors++;
                $display("FAIL rand_pre n=%0d W=%b A=%h got=%h exp=%h", n, WidthSrc, A, RD, exp_v);
            end
`ifdef DATAMEM_MISALIGN_CHECK_EN
            n_checks++;
            if (MisalignedFlag !== ref_misaligned(WidthSrc, A)) begin
                n_errors++;
                $display("FAIL rand_flag n=%0d got=%b exp=%b", n, MisalignedFlag, ref_misaligned(WidthSrc, A));
            end
`endif
            tick();
            if (WE) ref_write(WidthSrc, A, WD);
            exp_v = ref_read(WidthSrc, A);
            n_checks++;
            if (RD !== exp_v) begin
                n_errors++;
                $display("FAIL rand_post n=%0d W=%b A=%h got=%h exp=%h", n, WidthSrc, A, RD, exp_v);
            end
        end
    endtask

`ifdef DATAMEM_MISALIGN_CHECK_EN
    task automatic test_misalign();
        logic [31:0] before_v;
        drive(1'b0, 2'b00, 32'h4, 32'h0);
        #1;
        before_v = ref_read(2'b00, 32'h4);
        drive(1'b1, 2'b00, 32'h6, 32'h1234_5678);
        #1;
        n_checks++;
        if (MisalignedFlag !== 1'b1) begin
            n_errors++;
            $display("FAIL mis_word_flag got=%b exp=1", MisalignedFlag);
        end
        tick();
        drive(1'b0, 2'b00, 32'h4, 32'h0);
        #1;
        n_checks++;
        if (RD !== before_v) begin
            n_errors++;
            $display("FAIL mis_word_suppress got=%h exp=%h", RD, before_v);
        end
        drive(1'b1, 2'b10, 32'h6, 32'h0000_ABCD);
        #1;
        n_checks++;
        if (MisalignedFlag !== 1'b0) begin
            n_errors++;
            $display("FAIL mis_half_flag got=%b exp=0", MisalignedFlag);
        end
        tick();
        ref_write(2'b10, 32'h6, 32'h0000_ABCD);
        n_checks++;
        if (RD !== 32'h0000_ABCD) begin
            n_errors++;
            $display("FAIL mis_half_write got=%h exp=%h", RD, 32'h0000_ABCD);
        end
        WE = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        test_reset();
        test_word_fill();
        test_half_fill();
        test_byte_fill();
        test_partial();
`ifdef DATAMEM_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_reset_wins();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_data_mem
`default_nettype wire
